// File: rtl/uart_tx_csr_pkg.sv
// uart_tx_csr_pkg: shared definitions for the CSR-mapped UART transmitter.
//   - status word bit positions (read data)
//   - write-data field positions (start / char / stop)
//   - transmit FSM state type
//   - default CSR address
package uart_tx_csr_pkg;

    localparam logic [11:0] CSR_ADDR_DEFAULT = 12'h0FE;

    // Status word layout; bits [63:8] read as zero.
    localparam int unsigned STAT_COUNT_MSB = 3;
    localparam int unsigned STAT_FULL      = 4;
    localparam int unsigned STAT_EMPTY     = 5;
    localparam int unsigned STAT_BUSY      = 6;
    localparam int unsigned STAT_OVERRUN   = 7;

    // Write word layout: a push needs start=1 and stop=0.
    localparam int unsigned WR_START    = 11;
    localparam int unsigned WR_CHAR_MSB = 10;
    localparam int unsigned WR_CHAR_LSB = 3;
    localparam int unsigned WR_STOP     = 2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8-bit wide FIFO of depth 2**FIFO_AW for the UART transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is only accepted if a pop happens on the same edge.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   push_i, wdata_i  write request and data
//   pop_i            read request (ignored when empty)
//   rdata_o          head of the FIFO (valid when not empty)
//   count_o          number of stored entries
//   full_o, empty_o  status flags
module uart_tx_fifo #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o,
    output logic [FIFO_AW:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned Depth = 2 ** FIFO_AW;

    logic [FIFO_AW:0] wptr_q, rptr_q;
    logic [7:0]       mem_q [Depth];
    logic             push_ok, pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[FIFO_AW-1:0]];

    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_csr.sv
// uart_tx_csr: CSR-mapped 8N1 UART transmitter with an 8-entry character FIFO.
// Optional macro UART_TX_CSR_SIM_ECHO_EN: echo accepted characters and dropped
// pushes on the simulation console; without it the block is fully synthesizable.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   cadr_i          CSR address; cvalid_o flags a match with CSR_ADDR
//   cdat_o          status word when selected, else zero
//   cdat_i, cwe_i   write data / strobe (push char when start=1, stop=0)
//   coe_i           read strobe; a selected read clears sticky overrun
//   txd_o           serial output, idle high
module uart_tx_csr
    import uart_tx_csr_pkg::*;
#(
    parameter logic [11:0] CSR_ADDR = CSR_ADDR_DEFAULT,
    parameter int unsigned BAUD_DIV = 16,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] cadr_i,
    output logic        cvalid_o,
    output logic [63:0] cdat_o,
    input  logic [63:0] cdat_i,
    input  logic        coe_i,
    input  logic        cwe_i,
    output logic        txd_o
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);

    tx_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             ovr_q, ovr_d;
    logic             txd_q, txd_d;
    logic             busy, pop, cnt_end;

    logic             sel, wr_req, rd_clr, drop;
    logic [7:0]       f_rdata;
    logic [FIFO_AW:0] f_count;
    logic             f_full, f_empty;
    logic [7:0]       stat;

    logic unused_cdat;
    assign unused_cdat = ^{cdat_i[63:12], cdat_i[1:0]};

    assign sel    = (cadr_i == CSR_ADDR);
    assign wr_req = sel && cwe_i && cdat_i[WR_START] && !cdat_i[WR_STOP];
    assign rd_clr = sel && coe_i;
    // A push at full survives only if the transmitter frees a slot this edge.
    assign drop   = wr_req && f_full && !pop;

    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (wr_req),
        .pop_i   (pop),
        .wdata_i (cdat_i[WR_CHAR_MSB:WR_CHAR_LSB]),
        .rdata_o (f_rdata),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            txd_q   <= txd_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;
        cnt_end = (cnt_q == CntW'(BAUD_DIV - 1));

        unique case (state_q)
            StIdle: begin
                if (!f_empty) begin
                    state_d = StStart;
                    pop     = 1'b1;
                    data_d  = f_rdata;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    // Back-to-back frames: no idle bit between stop and start.
                    if (!f_empty) begin
                        state_d = StStart;
                        pop     = 1'b1;
                        data_d  = f_rdata;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear-on-read loses against a simultaneous drop.
        ovr_d = ovr_q;
        if (rd_clr) ovr_d = 1'b0;
        if (drop)   ovr_d = 1'b1;
    end

    // Outputs; txd is registered so the line is glitch-free.
    always_comb begin
        busy  = (state_q != StIdle);
        txd_d = 1'b1;
        unique case (state_q)
            StStart: txd_d = 1'b0;
            StData:  txd_d = data_q[bit_q];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        stat                   = '0;
        stat[STAT_COUNT_MSB:0] = 4'(f_count);
        stat[STAT_FULL]        = f_full;
        stat[STAT_EMPTY]       = f_empty;
        stat[STAT_BUSY]        = busy;
        stat[STAT_OVERRUN]     = ovr_q;
    end

    assign cvalid_o = sel;
    assign cdat_o   = sel ? {56'b0, stat} : 64'b0;
    assign txd_o    = txd_q;

`ifdef UART_TX_CSR_SIM_ECHO_EN
    always @(posedge clk_i) begin
        if (!reset_i && wr_req) begin
            if (drop) $display("@ OVERRUN");
            else      $display("%c", cdat_i[WR_CHAR_MSB:WR_CHAR_LSB]);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_csr.sv
// Directed self-checking bench for uart_tx_csr (BAUD_DIV=16, depth 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_csr;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [11:0] cadr_i = 12'h0FE;
    logic        cvalid_o;
    logic [63:0] cdat_o;
    logic [63:0] cdat_i = '0;
    logic        coe_i = 1'b0;
    logic        cwe_i = 1'b0;
    logic        txd_o;

    int n_checks = 0;
    int n_errors = 0;

    logic       txd_log  [0:511];
    logic       busy_log [0:511];
    logic [7:0] stat_log [0:511];

    always #5 clk_i = ~clk_i;

    uart_tx_csr #(
        .CSR_ADDR (12'h0FE),
        .BAUD_DIV (16),
        .FIFO_AW  (3)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .cadr_i   (cadr_i),
        .cvalid_o (cvalid_o),
        .cdat_o   (cdat_o),
        .cdat_i   (cdat_i),
        .coe_i    (coe_i),
        .cwe_i    (cwe_i),
        .txd_o    (txd_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_wr(input logic [7:0] c);
        return 64'h800 | (64'(c) << 3);
    endfunction

    // Sample index 1 is the current falling edge.
    task automatic capture(input int count);
        for (int n = 1; n <= count; n++) begin
            if (n > 1) @(negedge clk_i);
            txd_log[n]  = txd_o;
            busy_log[n] = cdat_o[6];
            stat_log[n] = cdat_o[7:0];
        end
    endtask

    task automatic count_busy(input int count, output int busy_n, output int first_low);
        busy_n    = 0;
        first_low = -1;
        for (int n = 1; n <= count; n++) begin
            if (busy_log[n]) busy_n++;
            if (first_low < 0 && txd_log[n] == 1'b0) first_low = n;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        logic [7:0] ch2;
        int         busy_n;
        int         first_low;
        int         done;
        int         lows;
        int         busys;

        // Reset state
        #1 reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("rst_cvalid", 64'(cvalid_o), 64'd1);
        check_eq("rst_cdat", cdat_o, 64'h20);
        check_eq("rst_txd", 64'(txd_o), 64'd1);
        reset_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_cdat", cdat_o, 64'h20);
        cadr_i = 12'h0FF;
        #1;
        check_eq("nosel_cvalid", 64'(cvalid_o), 64'd0);
        check_eq("nosel_cdat", cdat_o, 64'd0);
        cadr_i = 12'h0FE;

        // Single frame, char 0x41
        @(negedge clk_i);
        cdat_i = 64'h0000_0A08;
        cwe_i  = 1'b1;
        @(negedge clk_i);
        cwe_i = 1'b0;
        capture(400);
        count_busy(400, busy_n, first_low);
        check_eq("f1_stat_after_push", 64'(stat_log[1]), 64'h01);
        check_eq("f1_stat_started", 64'(stat_log[2]), 64'h60);
        check_eq("f1_txd_fall", 64'(first_low), 64'd3);
        check_eq("f1_busy_cycles", 64'(busy_n), 64'd160);
        check_eq("f1_start_bit", 64'(txd_log[11]), 64'd0);
        ch = 8'h41;
        for (int j = 0; j < 8; j++) begin
            check_eq($sformatf("f1_bit%0d", j), 64'(txd_log[11 + 16 * (j + 1)]), 64'(ch[j]));
        end
        check_eq("f1_stop_bit", 64'(txd_log[11 + 16 * 9]), 64'd1);
        check_eq("f1_idle_after", 64'(txd_log[163]), 64'd1);

        // Nine consecutive writes: first popped, eight stored
        for (int i = 0; i < 9; i++) begin
            cdat_i = mk_wr(8'h30 + 8'(i));
            cwe_i  = 1'b1;
            @(negedge clk_i);
        end
        cwe_i = 1'b0;
        check_eq("fill_stat", 64'(cdat_o[7:0]), 64'h58);
        @(negedge clk_i);
        cdat_i = mk_wr(8'h39);
        cwe_i  = 1'b1;
        @(negedge clk_i);
        cwe_i = 1'b0;
        check_eq("overrun_set", 64'(cdat_o[7:0]), 64'hD8);

        // Overrun clear-on-read behaviour
        @(negedge clk_i);
        check_eq("ovr_keep_no_oe", 64'(cdat_o[7]), 64'd1);
        coe_i = 1'b1;
        @(negedge clk_i);
        coe_i = 1'b0;
        check_eq("ovr_cleared", 64'(cdat_o[7:0]), 64'h58);
        cwe_i = 1'b1;
        @(negedge clk_i);
        cwe_i = 1'b0;
        check_eq("ovr_set_again", 64'(cdat_o[7]), 64'd1);
        cwe_i = 1'b1;
        coe_i = 1'b1;
        @(negedge clk_i);
        cwe_i = 1'b0;
        coe_i = 1'b0;
        check_eq("ovr_push_wins", 64'(cdat_o[7]), 64'd1);
        coe_i = 1'b1;
        @(negedge clk_i);
        coe_i = 1'b0;
        check_eq("ovr_clear2", 64'(cdat_o[7:0]), 64'h58);

        // Drain all queued frames
        done = 0;
        for (int n = 0; n < 3000 && done == 0; n++) begin
            @(negedge clk_i);
            if (cdat_o[7:0] == 8'h20) done = 1;
        end
        check_eq("drain_done", 64'(done), 64'd1);
        check_eq("drain_txd", 64'(txd_o), 64'd1);

        // Ignored writes: stop set, start clear
        cdat_i = 64'h0000_0A0C;
        cwe_i  = 1'b1;
        @(negedge clk_i);
        cwe_i = 1'b0;
        check_eq("ign_stop_stat", 64'(cdat_o[7:0]), 64'h20);
        cdat_i = 64'h0000_0208;
        cwe_i  = 1'b1;
        @(negedge clk_i);
        cwe_i = 1'b0;
        check_eq("ign_start_stat", 64'(cdat_o[7:0]), 64'h20);
        repeat (4) @(negedge clk_i);
        check_eq("ign_no_frame", 64'({txd_o, cdat_o[7:0]}), 64'h120);

        // Back-to-back frames 0x55, 0xAA
        ch  = 8'h55;
        ch2 = 8'hAA;
        cdat_i = mk_wr(ch);
        cwe_i  = 1'b1;
        @(negedge clk_i);
        cdat_i = mk_wr(ch2);
        @(negedge clk_i);
        cwe_i = 1'b0;
        capture(400);
        count_busy(400, busy_n, first_low);
        check_eq("b2b_push_pop_stat", 64'(stat_log[1]), 64'h41);
        check_eq("b2b_txd_fall", 64'(first_low), 64'd2);
        check_eq("b2b_busy_cycles", 64'(busy_n), 64'd320);
        check_eq("b2b_f1_bit0", 64'(txd_log[26]), 64'(ch[0]));
        check_eq("b2b_f2_start", 64'(txd_log[170]), 64'd0);
        check_eq("b2b_f2_bit1", 64'(txd_log[202]), 64'(ch2[1]));

        // Reset in the middle of DATA
        cdat_i = mk_wr(8'h00);
        cwe_i  = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        cwe_i = 1'b0;
        check_eq("mid_stat", 64'(cdat_o[7:0]), 64'h41);
        repeat (40) @(negedge clk_i);
        check_eq("mid_txd_low", 64'(txd_o), 64'd0);
        reset_i = 1'b1;
        #1;
        check_eq("mid_rst_txd", 64'(txd_o), 64'd1);
        check_eq("mid_rst_stat", 64'(cdat_o[7:0]), 64'h20);
        @(negedge clk_i);
        reset_i = 1'b0;
        lows  = 0;
        busys = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            if (txd_o == 1'b0) lows++;
            if (cdat_o[6]) busys++;
        end
        check_eq("post_rst_txd_lows", 64'(lows), 64'd0);
        check_eq("post_rst_busy", 64'(busys), 64'd0);
        check_eq("post_rst_stat", 64'(cdat_o[7:0]), 64'h20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
